// File: rtl/hack_instr_encoder_pkg.sv
// Shared Hack instruction field widths, code constants and packing helpers
// used by the encoder and any ROM-image builders.
package hack_instr_encoder_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned COMP_W  = 6;
    localparam int unsigned DEST_W  = 3;
    localparam int unsigned JUMP_W  = 3;

    localparam logic [2:0]        C_PREFIX      = 3'b111;
    localparam logic [COMP_W-1:0] COMP_D_PLUS_A = 6'b000010;
    localparam logic [COMP_W-1:0] COMP_ZERO     = 6'b101010;
    localparam logic [COMP_W-1:0] COMP_M_PLUS_1 = 6'b110111;
    localparam logic [JUMP_W-1:0] JMP_ALWAYS    = 3'b111;

    typedef struct packed {
        logic               is_c;
        logic [INSTR_W-1:0] value;
        logic               a;
        logic [COMP_W-1:0]  comp;
        logic [DEST_W-1:0]  dest;
        logic [JUMP_W-1:0]  jump;
    } hack_fields_t;

    function automatic logic [INSTR_W-1:0] hack_encode(input hack_fields_t f);
        if (f.is_c) begin
            return {C_PREFIX, f.a, f.comp, f.dest, f.jump};
        end
        return {1'b0, f.value[INSTR_W-2:0]};
    endfunction

    // An A-instruction constant must fit in 15 bits.
    function automatic logic hack_reject(input hack_fields_t f);
        return !f.is_c && f.value[INSTR_W-1];
    endfunction

endpackage

// File: rtl/hack_instr_encoder_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head shows the oldest entry,
// or the last word popped while empty.
module hack_instr_encoder_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
        rd_d    = do_pop ? rd_q + PTR_ONE : rd_q;
        last_d  = do_pop ? mem_q[rd_q[AW-1:0]] : last_q;
        head_o  = empty_o ? last_q : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            last_q <= last_d;
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/hack_instr_encoder.sv
// Packs A/C instruction field tuples into Hack words, queues them for the
// consumer and tracks rejected tuples and delivered words.
module hack_instr_encoder
    import hack_instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_is_c,
    input  logic [INSTR_W-1:0] in_value,
    input  logic               in_a,
    input  logic [COMP_W-1:0]  in_comp,
    input  logic [DEST_W-1:0]  in_dest,
    input  logic [JUMP_W-1:0]  in_jump,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic               err,
    output logic [CW-1:0]      err_count,
    output logic [INSTR_W-1:0] words_out
);

    hack_fields_t       fields;
    logic               accept;
    logic               reject;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [INSTR_W-1:0] word;

    logic               err_q, err_d;
    logic [CW-1:0]      err_count_q, err_count_d;
    logic [INSTR_W-1:0] words_q, words_d;

    always_comb begin
        fields = '{is_c: in_is_c, value: in_value, a: in_a,
                   comp: in_comp, dest: in_dest, jump: in_jump};
        word   = hack_encode(fields);
        reject = hack_reject(fields);
        accept = in_valid && in_ready;
        push   = accept && !reject;
        pop    = out_valid && out_ready;
    end

    hack_instr_encoder_sync_fifo #(
        .WIDTH(INSTR_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_data_i(word),
        .pop_i      (pop),
        .head_o     (out_instr),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_comb begin
        err_d       = accept && reject;
        err_count_d = err_count_q;
        if (err_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + CW'(1);
        end
        words_d = pop ? words_q + INSTR_W'(1) : words_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
            words_q     <= '0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
            words_q     <= words_d;
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign words_out = words_q;

endmodule

// File: tb/tb_hack_instr_encoder.sv
// Randomized and directed checks of hack_instr_encoder against a queue model.
module tb_hack_instr_encoder;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CW      = 4;
    localparam int unsigned ERR_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_is_c;
    logic [15:0]   in_value;
    logic          in_a;
    logic [5:0]    in_comp;
    logic [2:0]    in_dest;
    logic [2:0]    in_jump;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_instr;
    logic          err;
    logic [CW-1:0] err_count;
    logic [15:0]   words_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] q[$];
    logic [15:0] m_last;
    logic        m_err;
    int unsigned m_errcnt;
    logic [15:0] m_words;

    hack_instr_encoder #(
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_is_c  (in_is_c),
        .in_value (in_value),
        .in_a     (in_a),
        .in_comp  (in_comp),
        .in_dest  (in_dest),
        .in_jump  (in_jump),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .err      (err),
        .err_count(err_count),
        .words_out(words_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_encode(input logic is_c, input logic [15:0] value,
                                               input logic a, input logic [5:0] comp,
                                               input logic [2:0] dest, input logic [2:0] jump);
        int unsigned w;
        if (is_c) w = 32'hE000 + a * 4096 + comp * 64 + dest * 8 + jump;
        else      w = value % 32768;
        return w[15:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        bit acc;
        bit del;
        if (reset) begin
            q.delete();
            m_last   = 16'h0000;
            m_err    = 1'b0;
            m_errcnt = 0;
            m_words  = 16'h0000;
        end else begin
            acc   = in_valid && (q.size() < DEPTH);
            del   = (q.size() > 0) && out_ready;
            m_err = 1'b0;
            if (del) begin
                m_last  = q.pop_front();
                m_words = m_words + 16'd1;
            end
            if (acc) begin
                if (!in_is_c && in_value[15]) begin
                    m_err = 1'b1;
                    if (m_errcnt < ERR_MAX) m_errcnt++;
                end else begin
                    q.push_back(ref_encode(in_is_c, in_value, in_a, in_comp, in_dest, in_jump));
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [15:0] exp_head;
        exp_head = (q.size() > 0) ? q[0] : m_last;
        chk("m_in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
        chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("m_out_instr", 32'(out_instr), 32'(exp_head));
        chk("m_err",       32'(err),       32'(m_err));
        chk("m_err_count", 32'(err_count), m_errcnt);
        chk("m_words_out", 32'(words_out), 32'(m_words));
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic set_fields(input logic is_c, input logic [15:0] value, input logic a,
                              input logic [5:0] comp, input logic [2:0] dest, input logic [2:0] jump);
        in_is_c  = is_c;
        in_value = value;
        in_a     = a;
        in_comp  = comp;
        in_dest  = dest;
        in_jump  = jump;
    endtask

    task automatic send_one(input string tag, input logic is_c, input logic [15:0] value,
                            input logic a, input logic [5:0] comp, input logic [2:0] dest,
                            input logic [2:0] jump, input logic [15:0] exp_word);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_fields(is_c, value, a, comp, dest, jump);
        cycle();
        in_valid = 1'b0;
        chk({tag, "_word"},  32'(out_instr), 32'(exp_word));
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        cycle();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_fields(1'b0, 16'h0, 1'b0, 6'h0, 3'h0, 3'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'h0000);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_words_out", 32'(words_out), 32'd0);

        send_one("a5", 1'b0, 16'h0005, 1'b0, 6'h00, 3'h0, 3'h0, 16'h0005);
        chk("a5_words", 32'(words_out), 32'd1);
        send_one("dpa",  1'b1, 16'hFFFF, 1'b0, 6'b000010, 3'b010, 3'b000, 16'hE090);
        send_one("zjmp", 1'b1, 16'h1234, 1'b0, 6'b101010, 3'b000, 3'b111, 16'hEA87);
        send_one("mp1",  1'b1, 16'h0000, 1'b1, 6'b110111, 3'b001, 3'b000, 16'hFDC8);
        chk("held_after_drain", 32'(out_instr), 32'hFDC8);

        // Backpressure: five pushes into a four-entry queue
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_fields(1'b0, 16'(k), 1'b0, 6'h0, 3'h0, 3'h0);
            cycle();
        end
        chk("bp_full", 32'(in_ready), 32'd0);
        set_fields(1'b0, 16'd5, 1'b0, 6'h0, 3'h0, 3'h0);
        cycle();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_head1", 32'(out_instr), 32'd1);
        cycle();
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            chk("bp_order", 32'(out_instr), 32'(k));
            cycle();
        end
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_hold_last", 32'(out_instr), 32'd4);

        // Rejected A-type
        in_valid = 1'b1;
        set_fields(1'b0, 16'h8001, 1'b0, 6'h0, 3'h0, 3'h0);
        cycle();
        in_valid = 1'b0;
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_err_count", 32'(err_count), 32'd1);
        chk("rej_not_queued", 32'(out_valid), 32'd0);
        cycle();
        chk("rej_err_pulse", 32'(err), 32'd0);

        // Reset with three words queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_fields(1'b0, 16'(16'h0100 + k), 1'b0, 6'h0, 3'h0, 3'h0);
            cycle();
        end
        in_valid = 1'b0;
        chk("mid_queued", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_err_count", 32'(err_count), 32'd0);
        chk("mid_words_out", 32'(words_out), 32'd0);
        chk("mid_in_ready",  32'(in_ready),  32'd1);
        chk("mid_out_instr", 32'(out_instr), 32'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic; rejection rate high enough to reach saturation
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            set_fields($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1,
                       6'($urandom), 3'($urandom), 3'($urandom));
            if (!in_is_c && $urandom_range(0, 2) != 0) in_value[15] = 1'b0;
            cycle();
        end
        chk("sat_err_count", 32'(err_count), ERR_MAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_instr_encoder.md
Name: hack_instr_encoder

Overview:
- Encodes structured instruction fields (A-type value, or C-type a/comp/dest/jump) into 16-bit Hack machine words.
- Producer side of the instruction path: emits words in exactly the format the CPU's instruction decode consumes.
- Used by the program loader and the self-test sequencer to build ROM images in hardware.
- Valid/ready handshake on both sides, with a small output FIFO to decouple the loader from the ROM write port.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, 2..16.
- CW, 8, width of error counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  field tuple present.
- in_ready  output  1  encoder can accept a tuple this cycle.
- in_is_c  input  1  1 = C-instruction, 0 = A-instruction.
- in_value  input  16  A-instruction constant; bit 15 must be 0.
- in_a  input  1  C-instruction a-bit (A vs M operand).
- in_comp  input  6  C-instruction comp field.
- in_dest  input  3  C-instruction dest field.
- in_jump  input  3  C-instruction jump field.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer takes word this cycle.
- out_instr  output  16  encoded word (FIFO head).
- err  output  1  one-cycle pulse on rejected tuple.
- err_count  output  CW  saturating count of rejected tuples.
- words_out  output  16  count of words delivered, wraps at 2^16.

Behaviour:
- Reset (async assert, sync-released by system): FIFO empty, out_valid=0, out_instr=16'h0000, in_ready=1, err=0, err_count=0, words_out=0.
- Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
- Encoding for A-type (in_is_c=0): word = {1'b0, in_value[14:0]}.
- Encoding for C-type (in_is_c=1): word = {3'b111, in_a, in_comp, in_dest, in_jump}. in_value is ignored.
- Rejection: A-type with in_value[15]=1.
  - The tuple is consumed (handshake completes) but nothing is enqueued.
  - err=1 the following cycle.
  - err_count increments, saturating at 2^CW-1.
- Latency: a word accepted in cycle N is visible on out_instr/out_valid in cycle N+1 if the FIFO was empty. There is no combinational in-to-out path.
- in_ready = !full. Registered from FIFO occupancy; no dependence on out_ready, so there is no bypass when full.
- Simultaneous accept and deliver when neither empty nor full: occupancy unchanged, order preserved.
- Simultaneous accept and deliver when empty: new word appears next cycle; the delivered word is the existing head.
- out_instr holds the head stable while out_valid=1 && out_ready=0.
- When empty: out_instr holds its last value and out_valid=0.
- Pointer wrap-around: pointers are log2(DEPTH)+1 bits. full = MSBs differ and low bits equal; empty = pointers equal.
- words_out increments on each delivery and wraps 16'hFFFF→0.
- Reset mid-stream: FIFO contents discarded immediately and all counters cleared.

Decomposition:
- Shared header hack_defs.vh holds:
  - field widths (COMP_W=6, DEST_W=3, JUMP_W=3);
  - C-prefix constant 3'b111;
  - common comp/dest/jump code constants (COMP_D_PLUS_A=6'b000010, COMP_ZERO=6'b101010, COMP_M_PLUS_1=6'b110111, JMP_ALWAYS=3'b111).
- Natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty). The encoder core is combinational packing plus error and counter logic around it.

Test Plan:
- A-type, in_value=16'h0005, out_ready=1 → out_instr=16'h0005 one cycle after accept; words_out=1.
- C-type D=D+A (a=0, comp=000010, dest=010, jump=000) → 16'hE090.
- C-type 0;JMP (a=0, comp=101010, dest=000, jump=111) → 16'hEA87.
- C-type M=M+1 (a=1, comp=110111, dest=001, jump=000) → 16'hFDC8.
- Backpressure, out_ready=0, DEPTH=4:
  - push 5 tuples → in_ready=0 after the 4th accept;
  - release → words emitted in order, in_ready=1 the cycle after the first delivery.
- A-type in_value=16'h8001 → err pulse 1 cycle, err_count=1, nothing enqueued.
  - Then assert reset mid-burst with 3 words queued → out_valid=0, counters=0 immediately.
